// File: rtl/multiplier_unsigned.sv
// Two-stage pipelined wide unsigned multiplier. Operands and product use a redundant
// word+carry form: word i carries weight 2^(WORD_LEN*i), and its MSB is a carry into word i+1.
module multiplier_unsigned #(
  parameter int unsigned NUM_ELEMENTS = 17,
  parameter int unsigned BIT_LEN      = 17,
  parameter int unsigned WORD_LEN     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [BIT_LEN-1:0] A [NUM_ELEMENTS],
  input  logic [BIT_LEN-1:0] B [NUM_ELEMENTS],
  output logic               out_valid,
  output logic [BIT_LEN-1:0] M [2*NUM_ELEMENTS]
);

  localparam int unsigned NumCols = 2 * NUM_ELEMENTS;
  localparam int unsigned PpW     = 2 * BIT_LEN;
  localparam int unsigned HiW     = PpW - WORD_LEN;
  // Each column sums at most 2*NUM_ELEMENTS terms, the widest being a HiW-bit high half.
  localparam int unsigned ColW    = HiW + $clog2(2 * NUM_ELEMENTS + 1);

  logic               r_v1;
  logic               r_out_valid;
  logic [PpW-1:0]     r_pp [NUM_ELEMENTS][NUM_ELEMENTS];
  logic [BIT_LEN-1:0] r_m  [NumCols];
  logic [ColW-1:0]    w_col  [NumCols];
  logic [BIT_LEN-1:0] w_norm [NumCols];

  // Stage 1: partial products. Not reset; only consumed behind r_v1.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
          r_pp[i][j] <= PpW'(A[i]) * PpW'(B[j]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_v1        <= in_valid;
      r_out_valid <= r_v1;
    end
  end

  // Column compression: low half of A[i]*B[j] lands in column i+j, high half in i+j+1.
  always_comb begin
    for (int c = 0; c < NumCols; c++) begin
      w_col[c] = '0;
    end
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
        w_col[i+j]   = w_col[i+j]   + ColW'(r_pp[i][j][WORD_LEN-1:0]);
        w_col[i+j+1] = w_col[i+j+1] + ColW'(r_pp[i][j][PpW-1:WORD_LEN]);
      end
    end
  end

  // Single carry-normalise step: each column keeps its low word and takes the excess of the
  // column below, which is small enough to fit the carry bit. The top column absorbs the rest.
  always_comb begin
    for (int c = 0; c < NumCols; c++) begin
      w_norm[c] = '0;
    end
    w_norm[0] = BIT_LEN'(w_col[0][WORD_LEN-1:0]);
    for (int c = 1; c < NumCols - 1; c++) begin
      w_norm[c] = BIT_LEN'(w_col[c][WORD_LEN-1:0]) + BIT_LEN'(w_col[c-1][ColW-1:WORD_LEN]);
    end
    w_norm[NumCols-1] = BIT_LEN'(w_col[NumCols-1] + ColW'(w_col[NumCols-2][ColW-1:WORD_LEN]));
  end

  // Stage 2: product register, holds while no new result arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NumCols; c++) begin
        r_m[c] <= '0;
      end
    end else if (r_v1) begin
      for (int c = 0; c < NumCols; c++) begin
        r_m[c] <= w_norm[c];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign M         = r_m;

endmodule

// File: tb/tb_multiplier_unsigned.sv
// Directed self-checking bench for multiplier_unsigned: recombines the redundant product
// into a wide integer and compares it with hand-derived or big-integer reference values.
module tb_multiplier_unsigned;

  localparam int unsigned N  = 17;
  localparam int unsigned BL = 17;
  localparam int unsigned WL = 16;
  localparam int unsigned NC = 2 * N;
  localparam int unsigned BW = 560;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [BL-1:0] a [N];
  logic [BL-1:0] b [N];
  logic          out_valid;
  logic [BL-1:0] m [NC];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiplier_unsigned #(
    .NUM_ELEMENTS(N),
    .BIT_LEN     (BL),
    .WORD_LEN    (WL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (a),
    .B        (b),
    .out_valid(out_valid),
    .M        (m)
  );

  function automatic logic [BW-1:0] val_a();
    logic [BW-1:0] v = '0;
    for (int i = 0; i < N; i++) v += BW'(a[i]) << (WL * i);
    return v;
  endfunction

  function automatic logic [BW-1:0] val_b();
    logic [BW-1:0] v = '0;
    for (int i = 0; i < N; i++) v += BW'(b[i]) << (WL * i);
    return v;
  endfunction

  function automatic logic [BW-1:0] val_m();
    logic [BW-1:0] v = '0;
    for (int j = 0; j < NC; j++) begin
      v += BW'(m[j][WL-1:0]) << (WL * j);
      v += BW'(m[j][WL]) << (WL * (j + 1));
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
  endtask

  // Operands must already be set; returns 2 cycles after the vector is sampled.
  task automatic send_and_wait();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clear_ops();
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (val_m() !== '0) begin
      errors++;
      $display("FAIL reset_m: got %h want 0", val_m());
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero();
    clear_ops();
    for (int i = 0; i < N; i++) b[i] = BL'($urandom_range(0, 16'hFFFF));
    send_and_wait();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_out_valid: got %b want 1", out_valid);
    end
    checks++;
    if (val_m() !== '0) begin
      errors++;
      $display("FAIL zero_product: got %h want 0", val_m());
    end
  endtask

  task automatic test_ffff_word();
    logic [BW-1:0] exp_v;
    exp_v = BW'(32'hFFFE0001);
    clear_ops();
    a[0] = 17'h0FFFF;
    b[0] = 17'h0FFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ffff_early_valid: got %b want 0 after 1 cycle", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ffff_out_valid: got %b want 1", out_valid);
    end
    checks++;
    if (val_m() !== exp_v) begin
      errors++;
      $display("FAIL ffff_product: got %h want %h", val_m(), exp_v);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ffff_valid_drop: got %b want 0", out_valid);
    end
    checks++;
    if (val_m() !== exp_v) begin
      errors++;
      $display("FAIL ffff_hold: got %h want %h", val_m(), exp_v);
    end
  endtask

  task automatic test_carry_bit();
    logic [BW-1:0] exp_v;
    clear_ops();
    a[0] = 17'h10000;
    b[0] = 17'h00001;
    exp_v = BW'(1) << 16;
    send_and_wait();
    checks++;
    if (val_m() !== exp_v) begin
      errors++;
      $display("FAIL carry_lsw: got %h want %h", val_m(), exp_v);
    end
    // Carry bits in upper words: A = 2^16*2^48 = 2^64, B = 2^16*2^32 = 2^48.
    clear_ops();
    a[3] = 17'h10000;
    b[2] = 17'h10000;
    exp_v = BW'(1) << 112;
    send_and_wait();
    checks++;
    if (val_m() !== exp_v) begin
      errors++;
      $display("FAIL carry_upper: got %h want %h", val_m(), exp_v);
    end
  endtask

  task automatic test_full_scale();
    logic [BW-1:0] exp_v;
    logic [BW-1:0] mask545;
    for (int i = 0; i < N; i++) begin
      a[i] = 17'h0FFFF;
      b[i] = 17'h0FFFF;
    end
    exp_v = (BW'(1) << 544) - (BW'(1) << 273) + BW'(1);
    send_and_wait();
    checks++;
    if (val_m() !== exp_v) begin
      errors++;
      $display("FAIL full_ffff: got %h want %h", val_m(), exp_v);
    end
    // The all-1FFFF square slightly exceeds the 2^545 range that 34 word+carry outputs can
    // express, so only its low 545 bits are observable.
    for (int i = 0; i < N; i++) begin
      a[i] = 17'h1FFFF;
      b[i] = 17'h1FFFF;
    end
    mask545 = (BW'(1) << 545) - BW'(1);
    exp_v   = (val_a() * val_b()) & mask545;
    send_and_wait();
    checks++;
    if ((val_m() & mask545) !== exp_v) begin
      errors++;
      $display("FAIL full_1ffff: got %h want %h", val_m() & mask545, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] exp_v;
    for (int k = 0; k < 302; k++) begin
      if (k >= 2) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_valid[%0d]: got %b want 1", k - 2, out_valid);
        end
        checks++;
        if (val_m() !== exp_v) begin
          errors++;
          $display("FAIL b2b_product[%0d]: got %h want %h", k - 2, val_m(), exp_v);
        end
      end
      if (k < 300) begin
        for (int i = 0; i < N; i++) begin
          a[i] = BL'($urandom_range(0, 16'hFFFF));
          b[i] = BL'($urandom_range(0, 16'hFFFF));
        end
        exp_q.push_back(val_a() * val_b());
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    logic [BW-1:0] exp_v;
    clear_ops();
    a[0] = 17'h00003;
    b[0] = 17'h00005;
    in_valid = 1'b1;
    step();
    a[0] = 17'h00007;
    b[0] = 17'h0000B;
    rst_n = 1'b0;
    step();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (val_m() !== '0) begin
      errors++;
      $display("FAIL midreset_m: got %h want 0", val_m());
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale[%0d]: got %b want 0", k, out_valid);
      end
    end
    a[0] = 17'h00101;
    b[0] = 17'h00011;
    exp_v = BW'(32'h00001111);
    send_and_wait();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL postreset_valid: got %b want 1", out_valid);
    end
    checks++;
    if (val_m() !== exp_v) begin
      errors++;
      $display("FAIL postreset_product: got %h want %h", val_m(), exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_ffff_word();
    test_carry_bit();
    test_full_scale();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
